// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode values, ALUOp codes and the ALUSrcB / PCSource mux selects.
// Optional jump support is enabled by defining MCTRL_JUMP_EN.
package mctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_R_WB     = 4'd3,
      S_EXEC_I   = 4'd4,
      S_I_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_LW_WB    = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   // Opcode field values (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALUOp codes, zero-extended to ALUOP_W at the port
   localparam logic [3:0] ALUOP_FUNCT = 4'b0000;
   localparam logic [3:0] ALUOP_BEQ   = 4'b0100;
   localparam logic [3:0] ALUOP_BNE   = 4'b0101;
   localparam logic [3:0] ALUOP_ADD   = 4'b1000;
   localparam logic [3:0] ALUOP_SLT   = 4'b1010;
   localparam logic [3:0] ALUOP_SLTU  = 4'b1011;
   localparam logic [3:0] ALUOP_AND   = 4'b1100;
   localparam logic [3:0] ALUOP_OR    = 4'b1101;
   localparam logic [3:0] ALUOP_XOR   = 4'b1110;

   // ALU B-operand select
   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // PC source select; 11 is reserved for future use
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RSVD   = 2'b11;

endpackage

// File: rtl/mctrl_if.sv
// Control-unit <-> datapath bundle: opcode/mem_ready in, datapath enables and
// status out. master = control unit, slave = datapath side.
// JalLink exists only when MCTRL_JUMP_EN is defined.
interface mctrl_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 4,
   parameter int CNT_W    = 32
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                PCWrite;
   logic                PCWriteCond;
   logic                Branch_ne;
   logic                IorD;
   logic                MemRead;
   logic                MemWrite;
   logic                IRWrite;
   logic                MemtoReg;
   logic                RegDst;
   logic                RegWrite;
   logic                ALUSrcA;
   logic [1:0]          ALUSrcB;
   logic [1:0]          PCSource;
   logic [ALUOP_W-1:0]  ALUOp;
   logic                instr_done;
   logic                illegal_op;
   logic [CNT_W-1:0]    retired;
`ifdef MCTRL_JUMP_EN
   logic                JalLink;
`endif

   modport master (
`ifdef MCTRL_JUMP_EN
      output JalLink,
`endif
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite,
             IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
             PCSource, ALUOp, instr_done, illegal_op, retired
   );

   modport slave (
`ifdef MCTRL_JUMP_EN
      input  JalLink,
`endif
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite,
             IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
             PCSource, ALUOp, instr_done, illegal_op, retired
   );
endinterface

// File: rtl/mctrl_decode.sv
// Purely combinational state -> datapath-enable decoder (Moore on state,
// with mem_ready qualifying FETCH/MEM_WR strobes and opcode picking ALUOp).
// Latency 0; mem_ready low suppresses IRWrite/PCWrite in FETCH and instr_done in MEM_WR.
module mctrl_decode
   import mctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 4
) (
   input  state_t              state,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                op_legal,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                Branch_ne,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                MemtoReg,
   output logic                RegDst,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          PCSource,
   output logic [ALUOP_W-1:0]  ALUOp,
`ifdef MCTRL_JUMP_EN
   output logic                JalLink,
`endif
   output logic                instr_done,
   output logic                illegal_op
);

   logic [3:0] alu_code;

   assign ALUOp = ALUOP_W'(alu_code);

   // Per-state enables; everything not named in a state stays 0
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      Branch_ne   = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      PCSource    = PCSRC_ALU;
      alu_code    = ALUOP_FUNCT;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
`ifdef MCTRL_JUMP_EN
      JalLink     = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            MemRead  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
            alu_code = ALUOP_ADD;
            // IR and PC only update once memory has delivered the word
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
            end
         end
         S_DECODE: begin
            ALUSrcB    = SRCB_IMMSH;
            alu_code   = ALUOP_ADD;
            illegal_op = ~op_legal;
         end
         S_EXEC_R: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = SRCB_RT;
            alu_code = ALUOP_FUNCT;
         end
         S_R_WB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            case (opcode)
               OPCODE_W'(OP_SLTI):  alu_code = ALUOP_SLT;
               OPCODE_W'(OP_SLTIU): alu_code = ALUOP_SLTU;
               OPCODE_W'(OP_ANDI):  alu_code = ALUOP_AND;
               OPCODE_W'(OP_ORI):   alu_code = ALUOP_OR;
               OPCODE_W'(OP_XORI):  alu_code = ALUOP_XOR;
               default:             alu_code = ALUOP_ADD;
            endcase
         end
         S_I_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_ADDR: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = SRCB_IMM;
            alu_code = ALUOP_ADD;
         end
         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_LW_WB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_RT;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            Branch_ne   = (opcode == OPCODE_W'(OP_BNE));
            alu_code    = Branch_ne ? ALUOP_BNE : ALUOP_BEQ;
            instr_done  = 1'b1;
         end
`ifdef MCTRL_JUMP_EN
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            instr_done = 1'b1;
            // jal also writes the return address into $31
            if (opcode == OPCODE_W'(OP_JAL)) begin
               RegWrite = 1'b1;
               JalLink  = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with retired counter; MCTRL_JUMP_EN adds j/jal.
// Latency at mem_ready=1: R/I 4, lw 5, sw 4, branch 3 (jump 3) cycles; outputs are Moore on state.
// mem_ready low holds FETCH, MEM_RD and MEM_WR (wait states); it is ignored in every other state.
module multicycle_control
   import mctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 4,
   parameter int CNT_W    = 32
) (
   input logic    clk,
   input logic    reset,
   mctrl_if.master bus
);

   state_t           state;
   state_t           state_nxt;
   state_t           decode_nxt;
   logic             op_legal;
   logic             instr_done;
   logic [CNT_W-1:0] retired;

   assign bus.instr_done = instr_done;
   assign bus.retired    = retired;

   // Classify the opcode held in IR into the first execution state
   always_comb begin
      decode_nxt = S_FETCH;
      case (bus.opcode)
         OPCODE_W'(OP_RTYPE):                  decode_nxt = S_EXEC_R;
         OPCODE_W'(OP_ADDI), OPCODE_W'(OP_SLTI),
         OPCODE_W'(OP_SLTIU), OPCODE_W'(OP_ANDI),
         OPCODE_W'(OP_ORI), OPCODE_W'(OP_XORI): decode_nxt = S_EXEC_I;
         OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):   decode_nxt = S_MEM_ADDR;
         OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE): decode_nxt = S_BRANCH;
`ifdef MCTRL_JUMP_EN
         OPCODE_W'(OP_J), OPCODE_W'(OP_JAL):   decode_nxt = S_JUMP;
`endif
         default:                              decode_nxt = S_FETCH;
      endcase
      op_legal = (decode_nxt != S_FETCH);
   end

   // Next-state sequencing; wait states only in the memory-access states
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:    state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   state_nxt = decode_nxt;
         S_EXEC_R:   state_nxt = S_R_WB;
         S_EXEC_I:   state_nxt = S_I_WB;
         S_MEM_ADDR: state_nxt = (bus.opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_nxt = bus.mem_ready ? S_LW_WB : S_MEM_RD;
         S_MEM_WR:   state_nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
         default:    state_nxt = S_FETCH;
      endcase
   end

   // State register; reset aborts any instruction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= '0;
      end else if (instr_done) begin
         retired <= retired + 1'b1;
      end
   end

   mctrl_decode #(
      .OPCODE_W (OPCODE_W),
      .ALUOP_W  (ALUOP_W)
   ) u_decode (
      .state       (state),
      .opcode      (bus.opcode),
      .mem_ready   (bus.mem_ready),
      .op_legal    (op_legal),
      .PCWrite     (bus.PCWrite),
      .PCWriteCond (bus.PCWriteCond),
      .Branch_ne   (bus.Branch_ne),
      .IorD        (bus.IorD),
      .MemRead     (bus.MemRead),
      .MemWrite    (bus.MemWrite),
      .IRWrite     (bus.IRWrite),
      .MemtoReg    (bus.MemtoReg),
      .RegDst      (bus.RegDst),
      .RegWrite    (bus.RegWrite),
      .ALUSrcA     (bus.ALUSrcA),
      .ALUSrcB     (bus.ALUSrcB),
      .PCSource    (bus.PCSource),
      .ALUOp       (bus.ALUOp),
`ifdef MCTRL_JUMP_EN
      .JalLink     (bus.JalLink),
`endif
      .instr_done  (instr_done),
      .illegal_op  (bus.illegal_op)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors checked
// against hand-written expectations, with a 4-bit retired counter to exercise wrap.
// Define MCTRL_JUMP_EN to also cover j/jal.
module tb_multicycle_control;
   import mctrl_pkg::*;

   localparam int OPCODE_W = 6;
   localparam int ALUOP_W  = 4;
   localparam int CNT_W    = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mctrl_if #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

   multicycle_control #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Observed control word, MSB first:
   // PCWrite PCWriteCond Branch_ne IorD MemRead MemWrite IRWrite MemtoReg
   // RegDst RegWrite ALUSrcA ALUSrcB[1:0] PCSource[1:0] ALUOp[3:0] instr_done illegal_op
   logic [20:0] obs;
   assign obs = {bus.PCWrite, bus.PCWriteCond, bus.Branch_ne, bus.IorD, bus.MemRead,
                 bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                 bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.instr_done,
                 bus.illegal_op};

   localparam logic [20:0] PCW  = 21'd1 << 20;
   localparam logic [20:0] PCWC = 21'd1 << 19;
   localparam logic [20:0] BNE  = 21'd1 << 18;
   localparam logic [20:0] IORD = 21'd1 << 17;
   localparam logic [20:0] MRD  = 21'd1 << 16;
   localparam logic [20:0] MWR  = 21'd1 << 15;
   localparam logic [20:0] IRW  = 21'd1 << 14;
   localparam logic [20:0] MTR  = 21'd1 << 13;
   localparam logic [20:0] RDST = 21'd1 << 12;
   localparam logic [20:0] REGW = 21'd1 << 11;
   localparam logic [20:0] SRCA = 21'd1 << 10;
   localparam logic [20:0] DONE = 21'd1 << 1;
   localparam logic [20:0] ILL  = 21'd1;

   localparam logic [20:0] E_FETCH_W  = MRD | (21'd1 << 8) | (21'd8 << 2);
   localparam logic [20:0] E_FETCH_G  = E_FETCH_W | IRW | PCW;
   localparam logic [20:0] E_DECODE   = (21'd3 << 8) | (21'd8 << 2);
   localparam logic [20:0] E_EXEC_R   = SRCA;
   localparam logic [20:0] E_R_WB     = RDST | REGW | DONE;
   localparam logic [20:0] E_I_WB     = REGW | DONE;
   localparam logic [20:0] E_MEM_ADDR = SRCA | (21'd2 << 8) | (21'd8 << 2);
   localparam logic [20:0] E_MEM_RD   = IORD | MRD;
   localparam logic [20:0] E_LW_WB    = MTR | REGW | DONE;
   localparam logic [20:0] E_MEM_WR   = IORD | MWR;
   localparam logic [20:0] E_BEQ      = SRCA | PCWC | (21'd1 << 6) | (21'd4 << 2) | DONE;
   localparam logic [20:0] E_BNE      = SRCA | PCWC | BNE | (21'd1 << 6) | (21'd5 << 2) | DONE;
   localparam logic [20:0] E_EXEC_SLT = SRCA | (21'd2 << 8) | (21'd10 << 2);
   localparam logic [20:0] E_EXEC_OR  = SRCA | (21'd2 << 8) | (21'd13 << 2);
   localparam logic [20:0] E_JUMP     = PCW | (21'd2 << 6) | DONE;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // Drive mem_ready for this cycle, check the control word, advance one clock
   task automatic cyc(input string tag, input logic rdy, input logic [20:0] want);
      bus.mem_ready = rdy;
      #1;
      chk(tag, 32'(obs), 32'(want));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus.opcode    = OP_RTYPE;
      bus.mem_ready = 1'b0;
      reset         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_retired", 32'(bus.retired), 32'd0);
      cyc("rst_fetch", 1'b0, E_FETCH_W);

      // add: 4 cycles, RegWrite only in the last; mem_ready ignored in EXEC_R
      bus.opcode = OP_RTYPE;
      cyc("add_fetch", 1'b1, E_FETCH_G);
      cyc("add_decode", 1'b1, E_DECODE);
      cyc("add_exec", 1'b0, E_EXEC_R);
      chk("add_ret_before", 32'(bus.retired), 32'd0);
      cyc("add_wb", 1'b1, E_R_WB);
      chk("add_ret_after", 32'(bus.retired), 32'd1);

      // lw with 3 wait states in MEM_RD: 8 cycles total
      bus.opcode = OP_LW;
      cyc("lw_fetch", 1'b1, E_FETCH_G);
      cyc("lw_decode", 1'b1, E_DECODE);
      cyc("lw_addr", 1'b1, E_MEM_ADDR);
      cyc("lw_rd_w1", 1'b0, E_MEM_RD);
      cyc("lw_rd_w2", 1'b0, E_MEM_RD);
      cyc("lw_rd_w3", 1'b0, E_MEM_RD);
      cyc("lw_rd_ok", 1'b1, E_MEM_RD);
      cyc("lw_wb", 1'b1, E_LW_WB);
      chk("lw_ret", 32'(bus.retired), 32'd2);

      // bne: 3 cycles, done in cycle 3
      bus.opcode = OP_BNE;
      cyc("bne_fetch", 1'b1, E_FETCH_G);
      cyc("bne_decode", 1'b1, E_DECODE);
      cyc("bne_branch", 1'b1, E_BNE);
      chk("bne_ret", 32'(bus.retired), 32'd3);

      // Illegal opcode: pulse in DECODE, back to FETCH, counter unchanged
      bus.opcode = 6'b111111;
      cyc("ill_fetch", 1'b1, E_FETCH_G);
      cyc("ill_decode", 1'b1, E_DECODE | ILL);
      chk("ill_ret", 32'(bus.retired), 32'd3);
      cyc("ill_back", 1'b0, E_FETCH_W);

      // slti
      bus.opcode = OP_SLTI;
      cyc("slti_fetch", 1'b1, E_FETCH_G);
      cyc("slti_decode", 1'b1, E_DECODE);
      cyc("slti_exec", 1'b1, E_EXEC_SLT);
      cyc("slti_wb", 1'b1, E_I_WB);
      chk("slti_ret", 32'(bus.retired), 32'd4);

      // ori with a fetch wait state
      bus.opcode = OP_ORI;
      cyc("ori_fetch_w", 1'b0, E_FETCH_W);
      cyc("ori_fetch", 1'b1, E_FETCH_G);
      cyc("ori_decode", 1'b1, E_DECODE);
      cyc("ori_exec", 1'b1, E_EXEC_OR);
      cyc("ori_wb", 1'b1, E_I_WB);
      chk("ori_ret", 32'(bus.retired), 32'd5);

`ifdef MCTRL_JUMP_EN
      // j: 3 cycles, PCSource=10
      bus.opcode = OP_J;
      cyc("j_fetch", 1'b1, E_FETCH_G);
      cyc("j_decode", 1'b1, E_DECODE);
      bus.mem_ready = 1'b1;
      #1;
      chk("j_link", 32'(bus.JalLink), 32'd0);
      cyc("j_jump", 1'b1, E_JUMP);
      chk("j_ret", 32'(bus.retired), 32'd6);

      // jal: jump plus link write
      bus.opcode = OP_JAL;
      cyc("jal_fetch", 1'b1, E_FETCH_G);
      cyc("jal_decode", 1'b1, E_DECODE);
      bus.mem_ready = 1'b1;
      #1;
      chk("jal_link", 32'(bus.JalLink), 32'd1);
      cyc("jal_jump", 1'b1, E_JUMP | REGW);
      chk("jal_ret", 32'(bus.retired), 32'd7);
`else
      // Without jump support, j is an illegal opcode
      bus.opcode = 6'b000010;
      cyc("j_fetch", 1'b1, E_FETCH_G);
      cyc("j_decode_ill", 1'b1, E_DECODE | ILL);
      chk("j_ret", 32'(bus.retired), 32'd5);
`endif

      // sw aborted by reset while waiting in MEM_WR
      bus.opcode = OP_SW;
      cyc("sw_fetch", 1'b1, E_FETCH_G);
      cyc("sw_decode", 1'b1, E_DECODE);
      cyc("sw_addr", 1'b1, E_MEM_ADDR);
      cyc("sw_wr_w1", 1'b0, E_MEM_WR);
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      chk("sw_wr_w2", 32'(obs), 32'(E_MEM_WR));
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_mid_ret", 32'(bus.retired), 32'd0);
      cyc("rst_mid_fetch", 1'b0, E_FETCH_W);

      // 15 beq instructions fill the 4-bit counter, the 16th wraps it
      bus.opcode = OP_BEQ;
      for (int i = 1; i <= 16; i++) begin
         cyc("beq_fetch", 1'b1, E_FETCH_G);
         cyc("beq_decode", 1'b1, E_DECODE);
         cyc("beq_branch", 1'b1, E_BEQ);
         chk("beq_ret", 32'(bus.retired), 32'(i % 16));
      end
      cyc("wrap_fetch", 1'b0, E_FETCH_W);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
